execute_instruction: RTL and testbench
======================================

// Module: execute_instruction
// PURPOSE
//  Execute stage that consumes decode_instruction outputs (v/stall handshake, opecode, opr0/opr1, wb_r, pc).
//  Performs ALU/branch ops and drives the g_reg_x16 writeback port (wb/wb_r/result), or releases reservations.
//  Also drives branch/branch_addr into fetch_instruction and squashes wrong-path instructions after a taken branch.
// PARAMETERS
//  W_OPC  6   opcode width (params.v)
//  W_OPR  32  operand/result width (params.v)
//  W_RD   4   register index width (params.v)
//  ADDR   16  PC width (params.v)
// PORTS
//  clk            in   1      clock, posedge
//  reset          in   1      async, active-low
//  v_i            in   1      decode output valid
//  stall_o        out  1      back-pressure to decode stall_i
//  opecode_i      in   W_OPC  decoded opcode
//  opr0_i         in   W_OPR  operand 0
//  opr1_i         in   W_OPR  operand 1
//  wb_r_i         in   W_RD   destination register
//  pc_i           in   ADDR   PC of instruction
//  wb_o           out  1      regfile write strobe
//  wb_r_o         out  W_RD   regfile write index
//  result_o       out  W_OPR  regfile write data
//  cancel_o       out  1      release reservation without write
//  cancel_r_o     out  W_RD   register to release
//  branch         out  1      redirect fetch, 1-cycle pulse
//  branch_addr    out  ADDR   redirect target
// BEHAVIOUR
//  - Clock clk; reset asynchronous, active-low. Reset: all outputs 0, state IDLE, kill=0, mul counter 0.
//  - Accept when v_i && !stall_o at posedge. Outputs registered; every strobe lasts exactly one cycle.
//  - Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLL, 7 SRL, 8 SRA (shamt=opr1[4:0]),
//    9 SLT (signed, result 0/1), 10 MOV (=opr1), 11 JMP, 12 BZ, 13 BNZ, 14 MUL, 15 JAL; others = NOP.
//  - Writers (1-10, 14, 15): wb_o=1, wb_r_o=wb_r_i, result_o the cycle after accept (MUL: see below).
//    Arithmetic modulo 2^W_OPR, no flags. JAL result = pc_i+1 (zero-extended, ADDR wrap).
//  - Branches: JMP always; BZ if opr0==0; BNZ if opr0!=0; JAL always. Target = opr1[ADDR-1:0].
//    Taken: branch=1, branch_addr=target next cycle; set kill, store target. Not taken: no outputs.
//  - Kill mode: accepted instr with pc_i!=target is dropped; if writer opcode: cancel_o=1, cancel_r_o=wb_r_i;
//    never branches/writes. Instr with pc_i==target clears kill and executes normally in the same cycle.
//  - stall_o = (state==MUL). Decode holds its outputs while stall_o=1.
//  - FSM IDLE->MUL on accepted unkilled MUL; MUL counts W_OPR cycles (shift-add, 1 bit/cycle, low W_OPR bits);
//    on last count -> IDLE, wb_o pulse with product the next cycle; W_OPR+1 cycles accept->wb_o.
//  - Simultaneous: wb_o and cancel_o never both 1 (one instr per cycle). Killed MUL does not enter MUL.
//  - Reset mid-MUL: aborts to IDLE, no writeback; regfile reset clears reservations.
// CONFIGURATION
//  EXECUTE_MUL_EN defined: MUL as above.
//  Undefined: no multiplier/FSM, stall_o tied 0; opcode 14 writes result_o=0 next cycle (releases reservation).
// TESTING
//  1. ADD opr0=32'h00000005, opr1=32'hFFFFFFFF, wb_r=2 -> next cycle wb_o=1, wb_r_o=2, result_o=32'h00000004.
//  2. SRA opr0=32'h80000000, opr1=4; SLT opr0=-1, opr1=1 -> result_o=32'hF8000000, then 32'h00000001.
//  3. BZ opr0=0, opr1=16'h0040, pc 0x10; then pc 0x11 (ADD wb_r=3), pc 0x40 (MOV wb_r=5) ->
//     branch=1, branch_addr=0x0040; cancel_o=1, cancel_r_o=3; then wb_o=1, wb_r_o=5.
//  4. BNZ opr0=0 followed by ADD -> branch stays 0, ADD writes back normally, no cancel.
//  5. MUL_EN: MUL 32'h00012345 x 32'h00000100, v_i held with next ADD -> stall_o high 32 cycles,
//     wb_o result_o=32'h01234500 at cycle 33, ADD accepted after stall drops, written next cycle.
//  6. Reset low during MUL cycle 10 -> stall_o, wb_o, branch 0 immediately; after release next ADD works.

Source files
------------

// File: rtl/execute_instruction.sv
// execute_instruction: execute stage behind decode_instruction.
// Runs ALU and branch operations and registers the regfile writeback
// (wb_o/wb_r_o/result_o). It redirects fetch (branch/branch_addr) and then
// drops wrong-path instructions, releasing their reservations via cancel_o.
// Ports: clk, reset (async, active-low); decode side v_i, stall_o, opecode_i,
//        opr0_i, opr1_i, wb_r_i, pc_i; regfile side wb_o, wb_r_o, result_o,
//        cancel_o, cancel_r_o; fetch side branch, branch_addr.
// Build option: EXECUTE_MUL_EN adds the shift-add multiplier FSM for MUL.
// Without it, MUL writes 0 and stall_o stays low.
module execute_instruction #(
  parameter int unsigned W_OPC = 6,
  parameter int unsigned W_OPR = 32,
  parameter int unsigned W_RD  = 4,
  parameter int unsigned ADDR  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  output logic             stall_o,
  input  logic [W_OPC-1:0] opecode_i,
  input  logic [W_OPR-1:0] opr0_i,
  input  logic [W_OPR-1:0] opr1_i,
  input  logic [W_RD-1:0]  wb_r_i,
  input  logic [ADDR-1:0]  pc_i,
  output logic             wb_o,
  output logic [W_RD-1:0]  wb_r_o,
  output logic [W_OPR-1:0] result_o,
  output logic             cancel_o,
  output logic [W_RD-1:0]  cancel_r_o,
  output logic             branch,
  output logic [ADDR-1:0]  branch_addr
);
  localparam int unsigned W_SH = $clog2(W_OPR);

  localparam logic [W_OPC-1:0] OP_ADD = W_OPC'(1);
  localparam logic [W_OPC-1:0] OP_SUB = W_OPC'(2);
  localparam logic [W_OPC-1:0] OP_AND = W_OPC'(3);
  localparam logic [W_OPC-1:0] OP_OR  = W_OPC'(4);
  localparam logic [W_OPC-1:0] OP_XOR = W_OPC'(5);
  localparam logic [W_OPC-1:0] OP_SLL = W_OPC'(6);
  localparam logic [W_OPC-1:0] OP_SRL = W_OPC'(7);
  localparam logic [W_OPC-1:0] OP_SRA = W_OPC'(8);
  localparam logic [W_OPC-1:0] OP_SLT = W_OPC'(9);
  localparam logic [W_OPC-1:0] OP_MOV = W_OPC'(10);
  localparam logic [W_OPC-1:0] OP_JMP = W_OPC'(11);
  localparam logic [W_OPC-1:0] OP_BZ  = W_OPC'(12);
  localparam logic [W_OPC-1:0] OP_BNZ = W_OPC'(13);
  localparam logic [W_OPC-1:0] OP_MUL = W_OPC'(14);
  localparam logic [W_OPC-1:0] OP_JAL = W_OPC'(15);

  // Registered outputs, kill state and their next values
  logic             r_wb, w_wb;
  logic [W_RD-1:0]  r_wb_r, w_wb_r;
  logic [W_OPR-1:0] r_result, w_result;
  logic             r_cancel, w_cancel;
  logic [W_RD-1:0]  r_cancel_r, w_cancel_r;
  logic             r_branch, w_branch;
  logic [ADDR-1:0]  r_branch_addr, w_branch_addr;
  logic             r_kill, w_kill;
  logic [ADDR-1:0]  r_kill_pc, w_kill_pc;

  // Decode of the instruction currently presented
  logic             w_accept;
  logic             w_on_path;
  logic             w_writer;
  logic             w_taken;
  logic [W_OPR-1:0] w_alu;
  logic [W_SH-1:0]  w_shamt;
  logic [ADDR-1:0]  w_pc_inc;

`ifdef EXECUTE_MUL_EN
  localparam int unsigned W_CNT = $clog2(W_OPR);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state, w_state;
  logic [W_CNT-1:0] r_cnt, w_cnt;
  logic [W_OPR-1:0] r_mcand, w_mcand;
  logic [W_OPR-1:0] r_mplier, w_mplier;
  logic [W_OPR-1:0] r_acc, w_acc;
  logic [W_RD-1:0]  r_mul_rd, w_mul_rd;
  logic [W_OPR-1:0] w_step;

  assign stall_o = (r_state == S_MUL);
`else
  assign stall_o = 1'b0;
`endif

  // Operation decode and ALU
  always_comb begin
    w_accept  = v_i && !stall_o;
    w_on_path = !r_kill || (pc_i == r_kill_pc);
    w_shamt   = opr1_i[W_SH-1:0];
    w_pc_inc  = pc_i + ADDR'(1);
    w_writer  = 1'b0;
    w_taken   = 1'b0;
    w_alu     = '0;
    case (opecode_i)
      OP_ADD: begin w_writer = 1'b1; w_alu = opr0_i + opr1_i; end
      OP_SUB: begin w_writer = 1'b1; w_alu = opr0_i - opr1_i; end
      OP_AND: begin w_writer = 1'b1; w_alu = opr0_i & opr1_i; end
      OP_OR:  begin w_writer = 1'b1; w_alu = opr0_i | opr1_i; end
      OP_XOR: begin w_writer = 1'b1; w_alu = opr0_i ^ opr1_i; end
      OP_SLL: begin w_writer = 1'b1; w_alu = opr0_i << w_shamt; end
      OP_SRL: begin w_writer = 1'b1; w_alu = opr0_i >> w_shamt; end
      OP_SRA: begin w_writer = 1'b1; w_alu = $unsigned($signed(opr0_i) >>> w_shamt); end
      OP_SLT: begin w_writer = 1'b1; w_alu = W_OPR'($signed(opr0_i) < $signed(opr1_i)); end
      OP_MOV: begin w_writer = 1'b1; w_alu = opr1_i; end
      OP_JMP: w_taken = 1'b1;
      OP_BZ:  w_taken = (opr0_i == '0);
      OP_BNZ: w_taken = (opr0_i != '0);
      OP_MUL: w_writer = 1'b1;  // multiplier result, or 0 without the FSM
      OP_JAL: begin w_writer = 1'b1; w_taken = 1'b1; w_alu = W_OPR'(w_pc_inc); end
      default: ;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    w_wb          = 1'b0;
    w_wb_r        = r_wb_r;
    w_result      = r_result;
    w_cancel      = 1'b0;
    w_cancel_r    = r_cancel_r;
    w_branch      = 1'b0;
    w_branch_addr = r_branch_addr;
    w_kill        = r_kill;
    w_kill_pc     = r_kill_pc;
`ifdef EXECUTE_MUL_EN
    w_state  = r_state;
    w_cnt    = r_cnt;
    w_mcand  = r_mcand;
    w_mplier = r_mplier;
    w_acc    = r_acc;
    w_mul_rd = r_mul_rd;
    w_step   = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif
    if (w_accept) begin
      if (!w_on_path) begin
        // Wrong-path instruction: only release its reservation
        if (w_writer) begin
          w_cancel   = 1'b1;
          w_cancel_r = wb_r_i;
        end
      end else begin
        w_kill = 1'b0;
        if (w_taken) begin
          w_branch      = 1'b1;
          w_branch_addr = opr1_i[ADDR-1:0];
          w_kill        = 1'b1;
          w_kill_pc     = opr1_i[ADDR-1:0];
        end
`ifdef EXECUTE_MUL_EN
        if (opecode_i == OP_MUL) begin
          w_state  = S_MUL;
          w_cnt    = '0;
          w_acc    = '0;
          w_mcand  = opr0_i;
          w_mplier = opr1_i;
          w_mul_rd = wb_r_i;
        end else
`endif
        if (w_writer) begin
          w_wb     = 1'b1;
          w_wb_r   = wb_r_i;
          w_result = w_alu;
        end
      end
    end
`ifdef EXECUTE_MUL_EN
    // One multiplier bit per cycle; the last step writes back directly
    if (r_state == S_MUL) begin
      w_acc    = w_step;
      w_mcand  = r_mcand << 1;
      w_mplier = r_mplier >> 1;
      w_cnt    = r_cnt + W_CNT'(1);
      if (r_cnt == W_CNT'(W_OPR - 1)) begin
        w_state  = S_IDLE;
        w_cnt    = '0;
        w_wb     = 1'b1;
        w_wb_r   = r_mul_rd;
        w_result = w_step;
      end
    end
`endif
  end

`ifdef EXECUTE_MUL_EN
  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state;
  end

  // Multiplier datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_mul_rd <= '0;
    end else begin
      r_cnt    <= w_cnt;
      r_mcand  <= w_mcand;
      r_mplier <= w_mplier;
      r_acc    <= w_acc;
      r_mul_rd <= w_mul_rd;
    end
  end
`endif

  // Output and kill registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb          <= 1'b0;
      r_wb_r        <= '0;
      r_result      <= '0;
      r_cancel      <= 1'b0;
      r_cancel_r    <= '0;
      r_branch      <= 1'b0;
      r_branch_addr <= '0;
      r_kill        <= 1'b0;
      r_kill_pc     <= '0;
    end else begin
      r_wb          <= w_wb;
      r_wb_r        <= w_wb_r;
      r_result      <= w_result;
      r_cancel      <= w_cancel;
      r_cancel_r    <= w_cancel_r;
      r_branch      <= w_branch;
      r_branch_addr <= w_branch_addr;
      r_kill        <= w_kill;
      r_kill_pc     <= w_kill_pc;
    end
  end

  assign wb_o        = r_wb;
  assign wb_r_o      = r_wb_r;
  assign result_o    = r_result;
  assign cancel_o    = r_cancel;
  assign cancel_r_o  = r_cancel_r;
  assign branch      = r_branch;
  assign branch_addr = r_branch_addr;

endmodule

// File: tb/tb_execute_instruction.sv
// Directed testbench for execute_instruction. Instructions are driven at the
// falling edge and the registered outputs are sampled 1 time unit after the
// rising edge that accepts them.
module tb_execute_instruction;
  logic        clk = 1'b0;
  logic        reset;
  logic        v_i;
  logic        stall_o;
  logic [5:0]  opecode_i;
  logic [31:0] opr0_i, opr1_i;
  logic [3:0]  wb_r_i;
  logic [15:0] pc_i;
  logic        wb_o;
  logic [3:0]  wb_r_o;
  logic [31:0] result_o;
  logic        cancel_o;
  logic [3:0]  cancel_r_o;
  logic        branch;
  logic [15:0] branch_addr;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        wb;
  } vec_t;
  vec_t vecs [13];

  execute_instruction dut (
    .clk(clk), .reset(reset), .v_i(v_i), .stall_o(stall_o),
    .opecode_i(opecode_i), .opr0_i(opr0_i), .opr1_i(opr1_i),
    .wb_r_i(wb_r_i), .pc_i(pc_i), .wb_o(wb_o), .wb_r_o(wb_r_o),
    .result_o(result_o), .cancel_o(cancel_o), .cancel_r_o(cancel_r_o),
    .branch(branch), .branch_addr(branch_addr)
  );

  always #5 clk = ~clk;

  // Present one instruction and step past the edge that accepts it
  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] rd, input logic [15:0] pc);
    @(negedge clk);
    v_i = 1'b1; opecode_i = op; opr0_i = a; opr1_i = b; wb_r_i = rd; pc_i = pc;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    @(negedge clk);
    v_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; v_i = 1'b1; opecode_i = 6'd1; opr0_i = 32'd1; opr1_i = 32'd1;
    wb_r_i = 4'd1; pc_i = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (wb_o !== 1'b0 || result_o !== 32'h0 || wb_r_o !== 4'h0) begin
      n_err++;
      $display("FAIL reset_wb: wb_o=%b wb_r_o=%h result_o=%h, required 0/0/0", wb_o, wb_r_o, result_o);
    end
    n_vec++;
    if (stall_o !== 1'b0 || cancel_o !== 1'b0 || branch !== 1'b0 || branch_addr !== 16'h0) begin
      n_err++;
      $display("FAIL reset_ctl: stall=%b cancel=%b branch=%b addr=%h, required all 0",
               stall_o, cancel_o, branch, branch_addr);
    end
    @(negedge clk);
    v_i = 1'b0;
    reset = 1'b1;
  endtask

  // Back-to-back ALU operations, rd = table index
  task automatic test_alu();
    vecs[0]  = '{6'd1,  32'h00000005, 32'hFFFFFFFF, 32'h00000004, 1'b1};
    vecs[1]  = '{6'd2,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1};
    vecs[2]  = '{6'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1};
    vecs[3]  = '{6'd4,  32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b1};
    vecs[4]  = '{6'd5,  32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b1};
    vecs[5]  = '{6'd6,  32'h00000001, 32'h00000024, 32'h00000010, 1'b1};
    vecs[6]  = '{6'd7,  32'h80000000, 32'h00000004, 32'h08000000, 1'b1};
    vecs[7]  = '{6'd8,  32'h80000000, 32'h00000004, 32'hF8000000, 1'b1};
    vecs[8]  = '{6'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1};
    vecs[9]  = '{6'd9,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[10] = '{6'd10, 32'h00001234, 32'h0000ABCD, 32'h0000ABCD, 1'b1};
    vecs[11] = '{6'd0,  32'h00000001, 32'h00000001, 32'h00000000, 1'b0};
    vecs[12] = '{6'd63, 32'h00000001, 32'h00000001, 32'h00000000, 1'b0};
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i), 16'(i));
      n_vec++;
      if (vecs[i].wb) begin
        if (wb_o !== 1'b1 || wb_r_o !== 4'(i) || result_o !== vecs[i].exp || branch !== 1'b0) begin
          n_err++;
          $display("FAIL alu[%0d] op=%0d: wb=%b rd=%h res=%h br=%b, required 1/%h/%h/0",
                   i, vecs[i].op, wb_o, wb_r_o, result_o, branch, 4'(i), vecs[i].exp);
        end
      end else if (wb_o !== 1'b0 || cancel_o !== 1'b0 || branch !== 1'b0) begin
        n_err++;
        $display("FAIL alu_nop[%0d]: wb=%b cancel=%b br=%b, required 0/0/0", i, wb_o, cancel_o, branch);
      end
    end
    idle();
  endtask

  // JAL at the top of the PC range links to 0, then the target clears kill
  task automatic test_jal();
    send(6'd15, 32'h0, 32'h00000100, 4'd7, 16'hFFFF);
    n_vec++;
    if (wb_o !== 1'b1 || wb_r_o !== 4'd7 || result_o !== 32'h0 || branch !== 1'b1 || branch_addr !== 16'h0100) begin
      n_err++;
      $display("FAIL jal: wb=%b rd=%h res=%h br=%b addr=%h, required 1/7/00000000/1/0100",
               wb_o, wb_r_o, result_o, branch, branch_addr);
    end
    send(6'd1, 32'd1, 32'd1, 4'd1, 16'h0100);
    n_vec++;
    if (wb_o !== 1'b1 || result_o !== 32'd2 || cancel_o !== 1'b0 || branch !== 1'b0) begin
      n_err++;
      $display("FAIL jal_target: wb=%b res=%h cancel=%b br=%b, required 1/00000002/0/0",
               wb_o, result_o, cancel_o, branch);
    end
    idle();
  endtask

  // Taken BZ, then wrong-path instructions, then the target
  task automatic test_branch_kill();
    send(6'd12, 32'h0, 32'h00000040, 4'd0, 16'h0010);
    n_vec++;
    if (branch !== 1'b1 || branch_addr !== 16'h0040 || wb_o !== 1'b0) begin
      n_err++;
      $display("FAIL bz_taken: br=%b addr=%h wb=%b, required 1/0040/0", branch, branch_addr, wb_o);
    end
    send(6'd1, 32'd1, 32'd2, 4'd3, 16'h0011);
    n_vec++;
    if (cancel_o !== 1'b1 || cancel_r_o !== 4'd3 || wb_o !== 1'b0 || branch !== 1'b0) begin
      n_err++;
      $display("FAIL kill_add: cancel=%b r=%h wb=%b br=%b, required 1/3/0/0", cancel_o, cancel_r_o, wb_o, branch);
    end
    send(6'd13, 32'd1, 32'h00000080, 4'd0, 16'h0012);
    n_vec++;
    if (branch !== 1'b0 || cancel_o !== 1'b0 || wb_o !== 1'b0) begin
      n_err++;
      $display("FAIL kill_bnz: br=%b cancel=%b wb=%b, required 0/0/0", branch, cancel_o, wb_o);
    end
    send(6'd14, 32'd3, 32'd4, 4'd6, 16'h0013);
    n_vec++;
    if (cancel_o !== 1'b1 || cancel_r_o !== 4'd6 || stall_o !== 1'b0 || wb_o !== 1'b0) begin
      n_err++;
      $display("FAIL kill_mul: cancel=%b r=%h stall=%b wb=%b, required 1/6/0/0", cancel_o, cancel_r_o, stall_o, wb_o);
    end
    send(6'd10, 32'd0, 32'h00000077, 4'd5, 16'h0040);
    n_vec++;
    if (wb_o !== 1'b1 || wb_r_o !== 4'd5 || result_o !== 32'h77 || cancel_o !== 1'b0) begin
      n_err++;
      $display("FAIL target_mov: wb=%b rd=%h res=%h cancel=%b, required 1/5/00000077/0",
               wb_o, wb_r_o, result_o, cancel_o);
    end
    idle();
  endtask

  // Untaken BNZ and BZ leave the following ADDs alone
  task automatic test_not_taken();
    send(6'd13, 32'h0, 32'h00000200, 4'd0, 16'h0050);
    n_vec++;
    if (branch !== 1'b0 || wb_o !== 1'b0) begin
      n_err++;
      $display("FAIL bnz_nt: br=%b wb=%b, required 0/0", branch, wb_o);
    end
    send(6'd1, 32'd10, 32'd20, 4'd4, 16'h0051);
    n_vec++;
    if (wb_o !== 1'b1 || wb_r_o !== 4'd4 || result_o !== 32'd30 || cancel_o !== 1'b0 || branch !== 1'b0) begin
      n_err++;
      $display("FAIL nt_add: wb=%b rd=%h res=%h cancel=%b br=%b, required 1/4/0000001e/0/0",
               wb_o, wb_r_o, result_o, cancel_o, branch);
    end
    send(6'd12, 32'd5, 32'h00000300, 4'd0, 16'h0052);
    send(6'd2, 32'd9, 32'd4, 4'd8, 16'h0053);
    n_vec++;
    if (wb_o !== 1'b1 || wb_r_o !== 4'd8 || result_o !== 32'd5 || cancel_o !== 1'b0) begin
      n_err++;
      $display("FAIL bz_nt_sub: wb=%b rd=%h res=%h cancel=%b, required 1/8/00000005/0",
               wb_o, wb_r_o, result_o, cancel_o);
    end
    idle();
  endtask

`ifdef EXECUTE_MUL_EN
  // MUL stalls decode for 32 cycles while the next ADD waits on v_i
  task automatic test_mul();
    int n_stall;
    logic bad_wb;
    send(6'd14, 32'h00012345, 32'h00000100, 4'd9, 16'h0060);
    @(negedge clk);
    opecode_i = 6'd1; opr0_i = 32'd1; opr1_i = 32'd2; wb_r_i = 4'd10; pc_i = 16'h0061;
    n_stall = 0;
    bad_wb  = 1'b0;
    if (stall_o === 1'b1) n_stall = 1;
    for (int k = 0; k < 40 && n_stall > 0; k++) begin
      @(posedge clk); #1;
      if (stall_o !== 1'b1) break;
      n_stall++;
      if (wb_o !== 1'b0) bad_wb = 1'b1;
    end
    n_vec++;
    if (n_stall != 32 || bad_wb) begin
      n_err++;
      $display("FAIL mul_stall: stall cycles=%0d early_wb=%b, required 32/0", n_stall, bad_wb);
    end
    n_vec++;
    if (wb_o !== 1'b1 || wb_r_o !== 4'd9 || result_o !== 32'h01234500) begin
      n_err++;
      $display("FAIL mul_wb: wb=%b rd=%h res=%h, required 1/9/01234500", wb_o, wb_r_o, result_o);
    end
    @(posedge clk); #1;
    n_vec++;
    if (wb_o !== 1'b1 || wb_r_o !== 4'd10 || result_o !== 32'd3 || stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL mul_next_add: wb=%b rd=%h res=%h stall=%b, required 1/a/00000003/0",
               wb_o, wb_r_o, result_o, stall_o);
    end
    idle();
  endtask
`else
  // Without the multiplier, MUL writes 0 with no stall
  task automatic test_mul();
    send(6'd14, 32'd5, 32'd6, 4'd9, 16'h0060);
    n_vec++;
    if (wb_o !== 1'b1 || wb_r_o !== 4'd9 || result_o !== 32'h0 || stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL mul_off: wb=%b rd=%h res=%h stall=%b, required 1/9/00000000/0", wb_o, wb_r_o, result_o, stall_o);
    end
    send(6'd1, 32'd1, 32'd2, 4'd10, 16'h0061);
    n_vec++;
    if (wb_o !== 1'b1 || wb_r_o !== 4'd10 || result_o !== 32'd3) begin
      n_err++;
      $display("FAIL mul_off_next: wb=%b rd=%h res=%h, required 1/a/00000003", wb_o, wb_r_o, result_o);
    end
    idle();
  endtask
`endif

  // Asynchronous reset in mid-operation, then normal operation resumes
  task automatic test_reset_mid();
`ifdef EXECUTE_MUL_EN
    send(6'd14, 32'd7, 32'd7, 4'd1, 16'h0070);
    idle();
    repeat (8) @(posedge clk);
    #1;
    n_vec++;
    if (stall_o !== 1'b1) begin
      n_err++;
      $display("FAIL mid_mul_stall: stall=%b, required 1", stall_o);
    end
`else
    send(6'd11, 32'd0, 32'h00000300, 4'd0, 16'h0070);
    idle();
    #1;
`endif
    reset = 1'b0;
    #1;
    n_vec++;
    if (stall_o !== 1'b0 || wb_o !== 1'b0 || branch !== 1'b0 || cancel_o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: stall=%b wb=%b br=%b cancel=%b, required 0/0/0/0", stall_o, wb_o, branch, cancel_o);
    end
    @(negedge clk);
    reset = 1'b1;
    send(6'd1, 32'd7, 32'd8, 4'd2, 16'h0005);
    n_vec++;
    if (wb_o !== 1'b1 || wb_r_o !== 4'd2 || result_o !== 32'd15 || cancel_o !== 1'b0 || stall_o !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_add: wb=%b rd=%h res=%h cancel=%b stall=%b, required 1/2/0000000f/0/0",
               wb_o, wb_r_o, result_o, cancel_o, stall_o);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_jal();
    test_branch_kill();
    test_not_taken();
    test_mul();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
